ext_tile_bridge: RTL and testbench
==================================

Name: ext_tile_bridge

Overview:
- Sits directly downstream of the tile cache's external bus (extAddr/extData/extOE/extWR/extNotReady).
- Converts each word beat of a 16-word tile load or store into a single request/acknowledge transaction on the backing-memory port.
- Paces the cache by holding extNotReady high until that beat completes.
- Adds a per-beat timeout that raises an error, so a dead backing memory cannot hang the cache.

Parameters:
ADDR_W, 30, backing-memory word-address width (memAddr = extAddr[ADDR_W+1:2])
TIMEOUT_CYC, 255, REQ-state cycles without memAck before the beat is forced complete
ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out read

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
extAddr  in  32  byte address from cache; bits [1:0] ignored
extDataIn  in  32  write data from cache (tri-state merge done at top level)
extDataOut  out  32  read data to cache
extOE  in  1  cache requests a read beat
extWR  in  1  cache requests a write beat
extNotReady  out  1  high = beat not complete; low for exactly one cycle per completed beat
memReq  out  1  backing-memory request
memWe  out  1  1 = write, 0 = read; valid while memReq
memAddr  out  ADDR_W  word address; valid while memReq
memWData  out  32  write data; valid while memReq
memRData  in  32  read data, sampled on the cycle memAck=1
memAck  in  1  single-cycle acknowledge from backing memory
busErr  out  1  sticky timeout flag; cleared only by reset
beatCnt  out  16  completed beats, wraps 16'hFFFF->0

Behaviour:
- Clock is clock; reset is synchronous, active-high.
- Reset values: state=IDLE, extNotReady=1, memReq=0, memWe=0, memAddr=0, memWData=0, extDataOut=0, busErr=0, beatCnt=0, timeout counter=0.
- extNotReady is 1 in every state except DONE. This is required: the cache advances its word index on any cycle extNotReady=0.
- State machine, all outputs registered:
  - IDLE:
    - If exactly one of extOE/extWR is high: latch memAddr=extAddr[ADDR_W+1:2], memWe=extWR, memWData=extDataIn; clear timeout counter; go to REQ.
    - If extOE and extWR are both high: illegal; stay in IDLE with no request issued. The cache stalls.
    - If neither is high: stay in IDLE.
  - REQ:
    - memReq=1 with address, write-enable and data held stable.
    - memAck=1: on a read, extDataOut<=memRData; on a write, extDataOut is unchanged. Drop memReq and go to DONE.
    - Else if the timeout counter equals TIMEOUT_CYC-1: drop memReq, set busErr<=1, extDataOut<=ERR_DATA on a read, go to DONE.
    - Else increment the timeout counter.
  - DONE: extNotReady=0 for this one cycle; beatCnt+1; go to IDLE.
- Latency: request sampled in cycle t, memReq high from t+1; ack in cycle t+1+k gives DONE at t+2+k. Minimum 3 cycles per beat, so a 16-beat tile takes at least 48 cycles.
- extDataOut holds its value from the ack edge through DONE and beyond, until the next read ack. The cache captures it on the DONE edge.
- Back-to-back beats: after DONE the block is in IDLE and resamples extOE/extWR and the now-advanced extAddr. Store-to-load turnaround needs no special handling.
- extOE/extWR deasserting during REQ: the transaction is not aborted. It completes or times out, DONE still pulses, and the result is discarded by the cache.
- A memAck received while not in REQ is ignored.
- Reset mid-transaction: return to IDLE next edge and drop memReq immediately. The backing memory must tolerate an abandoned request.
- Timeout counter width is ceil(log2(TIMEOUT_CYC+1)). A TIMEOUT_CYC of 0 is illegal.

Test Plan:
- Read beat: extOE=1, extAddr=32'h0000_1040, memAck one cycle after memReq with memRData=32'h1234_5678 -> memAddr=30'h410, memWe=0, extNotReady low for 1 cycle, extDataOut=32'h1234_5678, beatCnt=1.
- 16-beat tile read with ack latency 0 and extAddr[5:2] advancing on each DONE -> exactly 16 DONE pulses spaced 3 cycles apart, addresses 0x400..0x40F in order, beatCnt=16.
- Write beat: extWR=1, extAddr=32'h0000_2000, extDataIn=32'hCAFE_F00D, ack after 5 cycles -> memWe=1, memWData=32'hCAFE_F00D held stable 6 cycles, one DONE pulse, extDataOut unchanged.
- Timeout: read with memAck never asserted, TIMEOUT_CYC=255 -> memReq high exactly 255 cycles, then DONE with extDataOut=32'hDEAD_BEEF and busErr=1, sticky through later good beats.
- Illegal and abort cases: extOE=extWR=1 -> no memReq and extNotReady stays 1. Then extOE alone, with reset asserted during REQ -> memReq=0, extNotReady=1, beatCnt=0 and busErr=0 on the cycle after reset.

Source files
------------

// File: rtl/ext_tile_bridge.sv
// Bridges the tile cache's external word bus onto a req/ack backing-memory port,
// one transaction per beat, with a per-beat timeout that sets a sticky error.
module ext_tile_bridge #(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       extAddr,
    input  logic [31:0]       extDataIn,
    output logic [31:0]       extDataOut,
    input  logic              extOE,
    input  logic              extWR,
    output logic              extNotReady,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWData,
    input  logic [31:0]       memRData,
    input  logic              memAck,
    output logic              busErr,
    output logic [15:0]       beatCnt
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  to_cnt, to_cnt_next;
    logic              req_next;
    logic              we_next;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       wdata_next;
    logic [31:0]       dout_next;
    logic              err_next;
    logic [15:0]       beat_next;
    logic              nrdy_next;

    // Byte-lane bits (and any bits above the word address) carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^extAddr;

    always_comb begin
        // NOTE: every target is given its hold value before the case so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_next  = state;
        to_cnt_next = to_cnt;
        req_next    = memReq;
        we_next     = memWe;
        addr_next   = memAddr;
        wdata_next  = memWData;
        dout_next   = extDataOut;
        err_next    = busErr;
        beat_next   = beatCnt;

        case (state)
            IDLE: begin
                // Both strobes high is illegal: no request, the cache simply stalls.
                if (extOE ^ extWR) begin
                    addr_next   = extAddr[ADDR_W+1:2];
                    we_next     = extWR;
                    wdata_next  = extDataIn;
                    to_cnt_next = '0;
                    req_next    = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (memAck) begin
                    if (!memWe) dout_next = memRData;
                    req_next   = 1'b0;
                    beat_next  = beatCnt + 16'd1;
                    state_next = DONE;
                end else if (to_cnt == TO_LAST) begin
                    if (!memWe) dout_next = ERR_DATA;
                    err_next   = 1'b1;
                    req_next   = 1'b0;
                    beat_next  = beatCnt + 16'd1;
                    state_next = DONE;
                end else begin
                    to_cnt_next = to_cnt + 1'b1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // The cache advances its word index on any cycle this is low.
        nrdy_next = (state_next != DONE);
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every flop samples
        // the pre-edge values, independent of statement order.
        if (reset) begin
            state       <= IDLE;
            to_cnt      <= '0;
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWData    <= '0;
            extDataOut  <= '0;
            busErr      <= 1'b0;
            beatCnt     <= '0;
            extNotReady <= 1'b1;
        end else begin
            state       <= state_next;
            to_cnt      <= to_cnt_next;
            memReq      <= req_next;
            memWe       <= we_next;
            memAddr     <= addr_next;
            memWData    <= wdata_next;
            extDataOut  <= dout_next;
            busErr      <= err_next;
            beatCnt     <= beat_next;
            extNotReady <= nrdy_next;
        end
    end

endmodule

// File: tb/tb_ext_tile_bridge.sv
// Randomized bench for ext_tile_bridge: the bench plays both the cache and the
// backing memory and predicts every beat from a word-addressed memory model.
module tb_ext_tile_bridge;

    localparam int          ADDR_W      = 30;
    localparam int          TIMEOUT_CYC = 255;
    localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       extAddr, extDataIn, extDataOut;
    logic              extOE, extWR, extNotReady;
    logic              memReq, memWe, memAck, busErr;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWData, memRData;
    logic [15:0]       beatCnt;

    ext_tile_bridge #(
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .ERR_DATA   (ERR_DATA)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .extAddr    (extAddr),
        .extDataIn  (extDataIn),
        .extDataOut (extDataOut),
        .extOE      (extOE),
        .extWR      (extWR),
        .extNotReady(extNotReady),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memRData   (memRData),
        .memAck     (memAck),
        .busErr     (busErr),
        .beatCnt    (beatCnt)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] mem [logic [29:0]];
    logic [31:0] exp_dout;
    logic [15:0] exp_beats;
    bit          exp_err;
    bit          in_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        exp_dout  = '0;
        exp_beats = '0;
        exp_err   = 1'b0;
        in_done   = 1'b0;
    endtask

    // One cache beat. delay >= 0: ack on REQ cycle delay+1; delay < 0: never ack.
    // Returns at the negedge inside DONE with the strobes still asserted.
    task automatic run_beat(input bit is_wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int delay,
                            output longint done_cyc);
        int          wait_n;
        int          req_n;
        int          exp_req;
        bit          hold_ok;
        logic [29:0] waddr;
        logic [31:0] rdata;
        waddr     = addr[31:2];
        rdata     = mem.exists(waddr) ? mem[waddr] : $urandom;
        extOE     = !is_wr;
        extWR     = is_wr;
        extAddr   = addr;
        extDataIn = wdata;
        memAck    = 1'b0;

        wait_n = 0;
        do begin
            memRData = $urandom;
            @(negedge clock);
            wait_n++;
        end while (memReq !== 1'b1 && wait_n < 8);
        check("req_latency", wait_n, in_done ? 32'd2 : 32'd1);

        req_n   = 0;
        hold_ok = 1'b1;
        while (memReq === 1'b1 && req_n < 400) begin
            req_n++;
            hold_ok &= (memAddr === waddr) && (memWe === is_wr) &&
                       (memWData === wdata) && (extNotReady === 1'b1);
            if (delay >= 0 && req_n == delay + 1) begin
                memAck   = 1'b1;
                memRData = rdata;
            end else begin
                memRData = $urandom;
            end
            @(negedge clock);
            memAck = 1'b0;
        end

        exp_req = (delay >= 0) ? delay + 1 : TIMEOUT_CYC;
        if (delay < 0) begin
            exp_err = 1'b1;
            if (!is_wr) exp_dout = ERR_DATA;
        end else if (is_wr) begin
            mem[waddr] = wdata;
        end else begin
            mem[waddr] = rdata;
            exp_dout   = rdata;
        end
        exp_beats = exp_beats + 16'd1;

        check("req_cycles", req_n, exp_req);
        check("req_hold", 32'(hold_ok), 32'd1);
        check("done_nrdy", 32'(extNotReady), 32'd0);
        check("done_dout", extDataOut, exp_dout);
        check("done_beats", 32'(beatCnt), 32'(exp_beats));
        check("done_err", 32'(busErr), 32'(exp_err));
        done_cyc = cyc;
        in_done  = 1'b1;
    endtask

    // Idle cycles with stray acks and noise on the read bus; nothing may move.
    task automatic idle(input int n);
        bit ok;
        ok        = 1'b1;
        extOE     = 1'b0;
        extWR     = 1'b0;
        extAddr   = $urandom;
        extDataIn = $urandom;
        repeat (n) begin
            memAck   = ($urandom_range(0, 2) == 0);
            memRData = $urandom;
            @(negedge clock);
            ok &= (memReq === 1'b0) && (extNotReady === 1'b1) &&
                  (extDataOut === exp_dout) && (beatCnt === exp_beats);
        end
        memAck = 1'b0;
        check("idle_quiet", 32'(ok), 32'd1);
        in_done = 1'b0;
    endtask

    initial begin
        longint dc [16];
        longint tmp;
        bit     ok;

        reset = 1'b1; extOE = 1'b0; extWR = 1'b0; memAck = 1'b0;
        extAddr = '0; extDataIn = '0; memRData = '0;
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_nrdy", 32'(extNotReady), 32'd1);
        check("rst_req", 32'(memReq), 32'd0);
        check("rst_we", 32'(memWe), 32'd0);
        check("rst_addr", 32'(memAddr), 32'd0);
        check("rst_wdata", memWData, 32'd0);
        check("rst_dout", extDataOut, 32'd0);
        check("rst_err", 32'(busErr), 32'd0);
        check("rst_beats", 32'(beatCnt), 32'd0);
        reset = 1'b0;
        idle(2);

        // Single read beat, ack one cycle after memReq rises
        mem[30'h410] = 32'h1234_5678;
        run_beat(1'b0, 32'h0000_1040, 32'h0, 1, tmp);
        check("read_dout", extDataOut, 32'h1234_5678);
        idle(2);

        // 16-beat tile read, zero ack latency, address advancing on each DONE
        for (int i = 0; i < 16; i++) begin
            run_beat(1'b0, 32'h0000_1000 + 32'(i) * 4, $urandom, 0, dc[i]);
            if (i > 0) check("tile_spacing", 32'(dc[i] - dc[i-1]), 32'd3);
        end
        check("tile_beats", 32'(beatCnt), 32'd17);
        idle(1);

        // Write beat, ack after 5 cycles: request held 6 cycles, read data untouched
        run_beat(1'b1, 32'h0000_2000, 32'hCAFE_F00D, 5, tmp);
        check("write_dout_kept", extDataOut, exp_dout);
        idle(2);

        // Dead memory: read times out
        run_beat(1'b0, 32'h0000_3400, $urandom, -1, tmp);
        check("timeout_dout", extDataOut, ERR_DATA);
        idle(2);

        // Randomized traffic; busErr must stay set throughout
        for (int i = 0; i < 40; i++) begin
            run_beat(1'($urandom_range(0, 1)),
                     32'h0000_3000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)),
                     $urandom, $urandom_range(0, 6), tmp);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        // Both strobes high: illegal, no request and no completion
        extOE = 1'b1; extWR = 1'b1; extAddr = 32'h0000_5000;
        ok = 1'b1;
        repeat (8) begin
            @(negedge clock);
            ok &= (memReq === 1'b0) && (extNotReady === 1'b1);
        end
        check("illegal_quiet", 32'(ok), 32'd1);

        // Read alone, then reset in the middle of the request
        extWR = 1'b0;
        @(negedge clock);
        check("abort_req_up", 32'(memReq), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_req", 32'(memReq), 32'd0);
        check("abort_nrdy", 32'(extNotReady), 32'd1);
        check("abort_beats", 32'(beatCnt), 32'd0);
        check("abort_err", 32'(busErr), 32'd0);
        reset = 1'b0;
        extOE = 1'b0;
        model_reset();
        idle(2);

        // Normal operation after the abort
        run_beat(1'b0, 32'h0000_1040, 32'h0, 2, tmp);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
